// File: rtl/counter_pwm_gen.sv
// PWM generator driven by an external free-running 8-bit count; pwm_out/wrap_pulse/cycle_cnt are registered (1 cycle).
// Duty updates use valid/ready: a single pending slot holds ready low until the next counter wrap applies it.
module counter_pwm_gen #(
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         count,
  input  logic [7:0]         duty_in,
  input  logic               duty_valid,
  output logic               duty_ready,
  output logic               pwm_out,
  output logic               wrap_pulse,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  logic [7:0] prev_count;
  logic [7:0] active_duty;
  logic [7:0] pending_duty;
  logic       pending_vld;
  logic       wrap;
  logic       apply;
  logic [7:0] eff_duty;

  assign duty_ready = !reset && !pending_vld;

  // Only a genuine FF->00 step counts; a stalled or jumping counter never wraps.
  assign wrap     = (prev_count == 8'hFF) && (count == 8'h00);
  assign apply    = wrap && pending_vld;
  assign eff_duty = apply ? pending_duty : active_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count   <= 8'h00;
      active_duty  <= 8'h00;
      pending_duty <= 8'h00;
      pending_vld  <= 1'b0;
      pwm_out      <= 1'b0;
      wrap_pulse   <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      prev_count <= count;
      pwm_out    <= (count < eff_duty);
      wrap_pulse <= wrap;
      // A handshake cannot coincide with apply: ready is low whenever a value is pending.
      if (apply) begin
        active_duty <= pending_duty;
        pending_vld <= 1'b0;
      end else if (duty_valid && duty_ready) begin
        pending_duty <= duty_in;
        pending_vld  <= 1'b1;
      end
      if (wrap && (cycle_cnt != {CYCLE_W{1'b1}})) begin
        cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_pwm_gen.sv
// Directed bench for counter_pwm_gen with CYCLE_W=2 so period-counter saturation is reachable.
module tb_counter_pwm_gen;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    count;
  logic [7:0]    duty_in;
  logic          duty_valid;
  logic          duty_ready;
  logic          pwm_out;
  logic          wrap_pulse;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Per-ramp observations
  int h_cnt, w_cnt, w_idx, acc_idx, stalls, last_hi;
  logic last_pwm;

  counter_pwm_gen #(.CYCLE_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives count lo..hi, one value per cycle, sampling outputs 1 time unit after each edge.
  // send_at/hold_at raise duty_valid with a value; it drops once the handshake completes.
  task automatic ramp(input int lo, input int hi,
                      input int send_at, input logic [7:0] send_val,
                      input int hold_at, input logic [7:0] hold_val);
    logic took;
    h_cnt = 0; w_cnt = 0; w_idx = -1; acc_idx = -1; stalls = 0; last_hi = -1; last_pwm = 1'b0;
    for (int c = lo; c <= hi; c++) begin
      if (c == send_at) begin duty_valid = 1'b1; duty_in = send_val; end
      if (c == hold_at) begin duty_valid = 1'b1; duty_in = hold_val; end
      count = 8'(c);
      took = duty_valid && duty_ready;
      if (duty_valid && !duty_ready) stalls++;
      @(posedge clk); #1;
      if (took) begin acc_idx = c; duty_valid = 1'b0; end
      if (pwm_out) begin h_cnt++; last_hi = c; end
      if (wrap_pulse) begin w_cnt++; w_idx = c; end
      last_pwm = pwm_out;
    end
  endtask

  initial begin
    int z_wraps, z_highs;
    reset = 1'b1; count = 8'h00; duty_in = 8'h00; duty_valid = 1'b0;

    // Reset held for two cycles while count ramps
    for (int i = 0; i < 2; i++) begin
      count = 8'(i);
      @(posedge clk); #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_cnt", cycle_cnt, 0);
      chk("rst_ready", duty_ready, 0);
    end
    reset = 1'b0;
    #1;
    chk("rel_ready", duty_ready, 1);

    // Accept 0x80, then non-wrap discontinuities: 0x37 -> 0x00 jump and 00 held for 10 cycles
    ramp(2, 8'h37, 2, 8'h80, -1, 8'h00);
    chk("pre_acc", acc_idx, 2);
    chk("pre_ready_lo", duty_ready, 0);
    z_wraps = 0; z_highs = 0;
    for (int i = 0; i < 10; i++) begin
      count = 8'h00;
      @(posedge clk); #1;
      z_wraps += int'(wrap_pulse);
      z_highs += int'(pwm_out);
    end
    chk("disc_wraps", z_wraps, 0);
    chk("disc_highs", z_highs, 0);
    chk("disc_cnt", cycle_cnt, 0);
    chk("disc_pending", duty_ready, 0);
    ramp(1, 255, -1, 8'h00, -1, 8'h00);
    chk("pre_highs", h_cnt, 0);
    chk("pre_wraps", w_cnt, 0);

    // Three periods at duty 0x80
    for (int p = 1; p <= 3; p++) begin
      ramp(0, 255, (p == 3) ? 8'h10 : -1, 8'h00, -1, 8'h00);
      chk("p80_highs", h_cnt, 128);
      chk("p80_last_hi", last_hi, 127);
      chk("p80_wraps", w_cnt, 1);
      chk("p80_wrap_idx", w_idx, 0);
      chk("p80_cnt", cycle_cnt, p);
    end
    chk("p3_acc", acc_idx, 8'h10);

    // Duty 0x00 period; counter now saturated
    ramp(0, 255, 8'h10, 8'hFF, -1, 8'h00);
    chk("d00_highs", h_cnt, 0);
    chk("d00_cnt_sat", cycle_cnt, 3);

    // Duty 0xFF period: low only for count FF
    ramp(0, 255, 8'h10, 8'h40, -1, 8'h00);
    chk("dff_highs", h_cnt, 255);
    chk("dff_last_hi", last_hi, 254);
    chk("dff_pwm_at_ff", last_pwm, 0);
    chk("dff_cnt_sat", cycle_cnt, 3);
    chk("dff_wraps", w_cnt, 1);

    // Duty 0x40 active; 0xC0 written at 0x10, 0x20 held from 0x20 and stalled
    ramp(0, 255, 8'h10, 8'hC0, 8'h20, 8'h20);
    chk("mid_highs", h_cnt, 64);
    chk("mid_acc", acc_idx, 8'h10);
    chk("mid_stalls", stalls, 224);
    chk("mid_ready", duty_ready, 0);
    ramp(0, 255, -1, 8'h00, -1, 8'h00);
    chk("c0_highs", h_cnt, 192);
    chk("c0_acc", acc_idx, 1);
    chk("c0_stalls", stalls, 1);
    ramp(0, 255, -1, 8'h00, -1, 8'h00);
    chk("d20_highs", h_cnt, 32);
    chk("d20_ready", duty_ready, 1);

    // Reset at count 0x50 with 0x90 pending
    ramp(0, 8'h4F, 5, 8'h90, -1, 8'h00);
    chk("pend_acc", acc_idx, 5);
    reset = 1'b1;
    count = 8'h50;
    @(posedge clk); #1;
    chk("mrst_cnt", cycle_cnt, 0);
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_ready", duty_ready, 0);
    reset = 1'b0;
    #1;
    chk("mrst_rel_ready", duty_ready, 1);
    ramp(8'h51, 255, -1, 8'h00, -1, 8'h00);
    chk("post_highs", h_cnt, 0);
    chk("post_wraps", w_cnt, 0);
    ramp(0, 255, -1, 8'h00, -1, 8'h00);
    chk("post2_highs", h_cnt, 0);
    chk("post2_wraps", w_cnt, 1);
    chk("post2_cnt", cycle_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_pwm_gen.md
# counter_pwm_gen

Downstream consumer of the 8-bit free-running `count` bus produced by the `counter` block. It compares `count` against a duty value to produce a registered PWM output and flags each counter wrap. It counts completed periods. Duty updates arrive over a valid/ready handshake and are double-buffered so that they take effect only at a period boundary, which keeps the output glitch-free.

## Interface
Parameters:
- `CYCLE_W`, default 16: width of the completed-period counter `cycle_cnt`; legal range 2..32.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset. Reset is synchronous and active-high, on the single clock `clk`.
- `count`, in, 8: current value from the upstream counter, sampled every cycle.
- `duty_in`, in, 8: new duty value; number of counts per period for which `pwm_out` is high.
- `duty_valid`, in, 1: `duty_in` is valid.
- `duty_ready`, out, 1: block can accept `duty_in`.
- `pwm_out`, out, 1: registered PWM output.
- `wrap_pulse`, out, 1: registered one-cycle pulse marking a counter wrap.
- `cycle_cnt`, out, CYCLE_W: number of completed periods, saturating.

## Operation
- **State:**
  - `prev_count[7:0]`: `count` from the previous cycle.
  - `active_duty[7:0]`.
  - `pending_duty[7:0]` and `pending_vld`.
  - Output registers `pwm_out`, `wrap_pulse`, `cycle_cnt`.
- **Reset** (`reset`=1 at a rising edge): all state clears to 0. This includes `active_duty`=0, `pending_vld`=0, `pwm_out`=0, `wrap_pulse`=0 and `cycle_cnt`=0.
- **`duty_ready`** is combinational: `duty_ready = !reset && !pending_vld`.
- **Handshake:**
  - A transfer occurs on an edge where `duty_valid && duty_ready`; it loads `pending_duty <= duty_in` and sets `pending_vld <= 1`.
  - The producer holds `duty_in` stable while `duty_valid`=1 and `duty_ready`=0.
- **Wrap detect** (combinational): `wrap = (prev_count == 8'hFF) && (count == 8'h00)`.
  - `count` held at 0, such as when the upstream counter is in reset, is never a wrap.
  - A jump from any value other than FF to 00 is never a wrap.
- **Effective duty:** `eff_duty = (wrap && pending_vld) ? pending_duty : active_duty`.
- **Every non-reset edge:**
  - `prev_count <= count`.
  - `pwm_out <= (count < eff_duty)`, an unsigned 8-bit compare.
  - `wrap_pulse <= wrap`.
  - If `wrap && pending_vld`: `active_duty <= pending_duty` and `pending_vld <= 0`.
  - If `wrap`: `cycle_cnt <= cycle_cnt + 1`, saturating at all-ones, where it holds.
- **Simultaneous events:**
  - **Wrap and handshake on the same edge:** only possible when `pending_vld`=0. The new value goes to pending and is applied at the next wrap, not this one.
  - **Wrap with `pending_vld`=1:** `duty_ready` is still 0 on that edge, so no new transfer occurs. `duty_ready` rises the following cycle.
- **Duty boundaries:**
  - `active_duty`=0: `pwm_out` is permanently 0.
  - `active_duty`=255: `pwm_out` is high for counts 0..254 and low for count 255.
  - A 100% duty cycle is not representable.

## Timing
- **`pwm_out` latency:** 1 cycle. The value after edge k reflects `count` and `eff_duty` during cycle k.
- **`wrap_pulse`:** high for exactly 1 cycle, in the cycle after the one where `count` reads 00 following FF.
- **`cycle_cnt`:** the new value is visible in the same cycle as `wrap_pulse`.
- **Duty application:** a duty accepted at any point in a period governs `pwm_out` starting with the sample of `count`=00 at the next wrap. It never applies mid-period.
- **Throughput:** at most one duty update per period; `duty_ready` stays low from acceptance until the applying wrap.
- **Reset mid-operation:**
  - The pending value is discarded.
  - `pwm_out` is 0 from the first cycle after reset.
  - The first wrap after reset requires a full FF→00 transition to be observed with `reset` deasserted.
- **Combinational paths:** none from inputs to `pwm_out`, `wrap_pulse` or `cycle_cnt`. `duty_ready` depends only on `reset` and state.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` for 2 cycles while `count` ramps.
  - Required: `pwm_out`=0, `wrap_pulse`=0, `cycle_cnt`=0, `duty_ready`=0 during reset; `duty_ready`=1 in the first cycle after release.
- **Basic PWM:**
  - Stimulus: write duty 0x80, then ramp `count` 00..FF over three periods.
  - Required: after the first wrap, `pwm_out` is high for exactly 128 consecutive cycles per 256. `wrap_pulse` fires once per period; `cycle_cnt` reads 1, 2, 3.
- **Boundary duties:**
  - Stimulus: apply duty 0x00 for one period, then duty 0xFF.
  - Required: with 0x00, 0 high cycles in the period. With 0xFF, 255 high cycles, and `pwm_out` is low exactly one cycle after `count`=FF.
- **Mid-period update and back-pressure:**
  - Stimulus: duty 0x40 is active. At `count`=0x10 write 0x C0; at `count`=0x20 hold `duty_valid` with 0x20.
  - Required: the second write stalls with `duty_ready`=0. The current period keeps 64 high cycles and the next period has 192. 0x20 is accepted 1 cycle after the wrap and applies one period later.
- **Non-wrap discontinuities:**
  - Stimulus: hold `count`=00 for 10 cycles, then jump 0x37→0x00.
  - Required: no `wrap_pulse`, `cycle_cnt` unchanged, pending duty not applied.
- **Saturation and reset mid-period:**
  - Stimulus: with `CYCLE_W`=2, run 5 periods, then assert `reset` at `count`=0x50 with a duty pending.
  - Required: `cycle_cnt` reads 1, 2, 3, 3, 3. After reset `cycle_cnt`=0 and the pending duty is never applied.
